// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported word memory.
// Handles byte/half/word loads with extension and byte/half stores by read-modify-write.
module data_mem_arbiter #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [1:0]  a_size,
   input  logic        a_uns,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_ready,
   output logic [31:0] a_rdata,
   output logic        a_err,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [1:0]  b_size,
   input  logic        b_uns,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_ready,
   output logic [31:0] b_rdata,
   output logic        b_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

   state_t      state;
   logic        grant_b;
   logic        last_b;
   logic        we_q;
   logic        uns_q;
   logic        err_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [31:0] merge_q;

   logic        pick_b;
   logic        word_store;
   logic        req_err;
   logic [4:0]  lane_shift;
   logic [31:0] lane_word;
   logic [31:0] lane_mask;
   logic [31:0] load_val;
   logic [31:0] merged;

   // With both ports asking, the one that did not win last time gets the memory.
   assign pick_b     = b_req && (!a_req || !last_b);
   assign word_store = we_q && (size_q == 2'b10);
   assign lane_shift = {addr_q[1:0], 3'b000};

   always_comb begin
      req_err = 1'b0;
      if (size_q == 2'b11)
         req_err = 1'b1;
      if ((size_q == 2'b01) && addr_q[0])
         req_err = 1'b1;
      if ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
         req_err = 1'b1;
      if ((addr_q >> (ADDR_W + 2)) != 32'd0)
         req_err = 1'b1;
   end

   always_comb begin
      lane_word = mem_rdata >> lane_shift;
      load_val  = mem_rdata;
      case (size_q)
         2'b00:   load_val = uns_q ? {24'd0, lane_word[7:0]}
                                   : {{24{lane_word[7]}}, lane_word[7:0]};
         2'b01:   load_val = uns_q ? {16'd0, lane_word[15:0]}
                                   : {{16{lane_word[15]}}, lane_word[15:0]};
         default: load_val = mem_rdata;
      endcase
   end

   // Sub-word stores splice the new lane into the word just read back.
   assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
   assign merged    = (mem_rdata & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

   assign mem_addr  = 32'(addr_q[ADDR_W+1:2]);
   assign mem_we    = !rst && (((state == ACCESS) && !req_err && word_store) || (state == WRITE));
   assign mem_wdata = !mem_we ? 32'd0 : ((state == WRITE) ? merge_q : wdata_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant_b <= 1'b0;
         last_b  <= 1'b1;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         merge_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (a_req || b_req) begin
                  grant_b <= pick_b;
                  last_b  <= pick_b;
                  we_q    <= pick_b ? b_we    : a_we;
                  size_q  <= pick_b ? b_size  : a_size;
                  uns_q   <= pick_b ? b_uns   : a_uns;
                  addr_q  <= pick_b ? b_addr  : a_addr;
                  wdata_q <= pick_b ? b_wdata : a_wdata;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               err_q   <= req_err;
               rdata_q <= 32'd0;
               if (req_err || word_store) begin
                  state <= DONE;
               end else if (!we_q) begin
                  rdata_q <= load_val;
                  state   <= DONE;
               end else begin
                  merge_q <= merged;
                  state   <= WRITE;
               end
            end
            WRITE:   state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   assign a_ready = (state == DONE) && !grant_b;
   assign b_ready = (state == DONE) && grant_b;
   assign a_err   = a_ready && err_q;
   assign b_err   = b_ready && err_q;
   assign a_rdata = a_ready ? rdata_q : 32'd0;
   assign b_rdata = b_ready ? rdata_q : 32'd0;

endmodule
